// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer (mm:ss style) with preset load, clear, start/stop and expiry flag.
// Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last preset on expiry instead of stopping.
module bcd_countdown_timer #(
   parameter int DIGITS     = 4,
   parameter int TENS_RADIX = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   preset,
   input  logic                  start,
   input  logic                  stop,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  paused,
   output logic                  expired,
   output logic                  done
);

   localparam int         W        = 4 * DIGITS;
   localparam logic [3:0] UNIT_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'(TENS_RADIX - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_count;
   logic [W-1:0]   w_count_nxt;
   logic [W-1:0]   w_sat;
   logic [W-1:0]   w_dec;
   logic           r_done;
   logic           w_done_nxt;
   logic           w_count_zero;
   logic           w_dec_zero;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
   logic [W-1:0]   r_shadow;
   logic [W-1:0]   w_shadow_nxt;
`endif

   // Clamp each preset digit to its own radix: odd digits are tens, even digits are units.
   always_comb begin
      w_sat = '0;
      for (int i = 0; i < DIGITS; i++) begin
         logic [3:0] v_lim;
         v_lim = (i % 2 != 0) ? TENS_MAX : UNIT_MAX;
         w_sat[4*i +: 4] = (preset[4*i +: 4] > v_lim) ? v_lim : preset[4*i +: 4];
      end
   end

   // Borrow ripples up from digit 0; a zero digit wraps to its radix-1.
   always_comb begin
      logic v_borrow;
      logic [3:0] v_lim;
      logic [3:0] v_dig;
      w_dec    = '0;
      v_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         v_lim = (i % 2 != 0) ? TENS_MAX : UNIT_MAX;
         v_dig = r_count[4*i +: 4];
         if (!v_borrow) begin
            w_dec[4*i +: 4] = v_dig;
         end else if (v_dig == 4'd0) begin
            w_dec[4*i +: 4] = v_lim;
         end else begin
            w_dec[4*i +: 4] = v_dig - 4'd1;
            v_borrow        = 1'b0;
         end
      end
   end

   assign w_count_zero = (r_count == '0);
   assign w_dec_zero   = (w_dec == '0);

   // NOTE: every signal written below gets a default first so no latch is inferred on untaken branches.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_done_nxt   = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      w_shadow_nxt = r_shadow;
`endif
      if (clear) begin
         w_count_nxt  = '0;
         w_state_nxt  = S_IDLE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         w_shadow_nxt = '0;
`endif
      end else if (load) begin
         w_count_nxt  = w_sat;
         w_state_nxt  = S_IDLE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         w_shadow_nxt = w_sat;
`endif
      end else if (stop) begin
         if (r_state == S_RUN) w_state_nxt = S_PAUSE;
      end else if (start) begin
         if ((r_state == S_IDLE || r_state == S_PAUSE) && !w_count_zero) w_state_nxt = S_RUN;
      end else if (tick && r_state == S_RUN) begin
         w_count_nxt = w_dec;
         if (w_dec_zero) begin
            w_done_nxt = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (r_shadow != '0) w_count_nxt = r_shadow;
            else                w_state_nxt = S_DONE;
`else
            w_state_nxt = S_DONE;
`endif
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_done   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         r_shadow <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_done   <= w_done_nxt;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         r_shadow <= w_shadow_nxt;
`endif
      end
   end

   assign count   = r_count;
   assign running = (r_state == S_RUN);
   assign paused  = (r_state == S_PAUSE);
   assign expired = (r_state == S_DONE);
   assign done    = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=4): driver queues expected outputs, monitor compares each cycle.
module tb_bcd_countdown_timer;

   typedef struct {
      string       name;
      logic [15:0] count;
      logic        running;
      logic        paused;
      logic        expired;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [15:0] preset = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] count;
   logic        running;
   logic        paused;
   logic        expired;
   logic        done;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   auto_rl;

   bcd_countdown_timer #(.DIGITS(4), .TENS_RADIX(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .clear   (clear),
      .load    (load),
      .preset  (preset),
      .start   (start),
      .stop    (stop),
      .count   (count),
      .running (running),
      .paused  (paused),
      .expired (expired),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Monitor: the DUT presents a fresh result every cycle, so pop one expectation per edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if (count === mon_e.count && running === mon_e.running && paused === mon_e.paused &&
             expired === mon_e.expired && done === mon_e.done) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got count=%h run=%b pau=%b exp=%b done=%b, want count=%h run=%b pau=%b exp=%b done=%b",
                     mon_e.name, count, running, paused, expired, done,
                     mon_e.count, mon_e.running, mon_e.paused, mon_e.expired, mon_e.done);
         end
      end
   end

   function automatic logic [15:0] mmss(input int secs);
      int m;
      int s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step(input string name, input logic r, c, l, input logic [15:0] p,
                       input logic sta, sto, t, input logic [15:0] ec,
                       input logic er, ep, ee, ed);
      exp_t e;
      @(negedge clk);
      rst = r; clear = c; load = l; preset = p; start = sta; stop = sto; tick = t;
      e.name = name; e.count = ec; e.running = er; e.paused = ep; e.expired = ee; e.done = ed;
      exp_q.push_back(e);
   endtask

   initial begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      auto_rl = 1'b1;
`else
      auto_rl = 1'b0;
`endif
      //   name             rst clr ld preset    sta sto tck  count    run pau exp done
      step("reset",          1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000, 0, 0, 0, 0);
      step("start_at_zero",  0, 0, 0, 16'h0000, 1, 0, 0,   16'h0000, 0, 0, 0, 0);
      step("load_0102",      0, 0, 1, 16'h0102, 0, 0, 0,   16'h0102, 0, 0, 0, 0);
      step("stop_in_idle",   0, 0, 0, 16'h0000, 0, 1, 0,   16'h0102, 0, 0, 0, 0);
      step("tick_in_idle",   0, 0, 0, 16'h0000, 0, 0, 1,   16'h0102, 0, 0, 0, 0);
      step("start_0102",     0, 0, 0, 16'h0000, 1, 0, 0,   16'h0102, 1, 0, 0, 0);
      for (int k = 1; k < 62; k++)
         step("countdown",   0, 0, 0, 16'h0000, 0, 0, 1,   mmss(62 - k), 1, 0, 0, 0);
      if (auto_rl) begin
         step("expiry_reload", 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
         exp_q[exp_q.size()-1] = '{"expiry_reload", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      // The final tick: swap the provisional entry above for the build-specific expectation.
      if (auto_rl) begin
         void'(exp_q.pop_back());
         step("expiry_reload", 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0102, 1, 0, 0, 1);
         step("after_reload",  0, 0, 0, 16'h0000, 0, 0, 0, 16'h0102, 1, 0, 0, 0);
         step("start_in_run",  0, 0, 0, 16'h0000, 1, 0, 0, 16'h0102, 1, 0, 0, 0);
      end else begin
         step("expiry",        0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1, 1);
         step("done_one_cycle",0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
         step("start_in_done", 0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 1, 0);
      end
      step("load_1000",      0, 0, 1, 16'h1000, 0, 0, 0,   16'h1000, 0, 0, 0, 0);
      step("start_1000",     0, 0, 0, 16'h0000, 1, 0, 0,   16'h1000, 1, 0, 0, 0);
      step("borrow_chain",   0, 0, 0, 16'h0000, 0, 0, 1,   16'h0959, 1, 0, 0, 0);
      step("stop",           0, 0, 0, 16'h0000, 0, 1, 0,   16'h0959, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++)
         step("tick_paused", 0, 0, 0, 16'h0000, 0, 0, 1,   16'h0959, 0, 1, 0, 0);
      step("resume",         0, 0, 0, 16'h0000, 1, 0, 0,   16'h0959, 1, 0, 0, 0);
      step("tick_resumed",   0, 0, 0, 16'h0000, 0, 0, 1,   16'h0958, 1, 0, 0, 0);
      step("load_saturate",  0, 0, 1, 16'h9F7A, 0, 0, 0,   16'h5959, 0, 0, 0, 0);
      step("clear_over_load",0, 1, 1, 16'h1234, 0, 0, 0,   16'h0000, 0, 0, 0, 0);
      step("load_0005",      0, 0, 1, 16'h0005, 0, 0, 0,   16'h0005, 0, 0, 0, 0);
      step("start_0005",     0, 0, 0, 16'h0000, 1, 0, 0,   16'h0005, 1, 0, 0, 0);
      step("stop_start_tick",0, 0, 0, 16'h0000, 1, 1, 1,   16'h0005, 0, 1, 0, 0);
      step("resume_0005",    0, 0, 0, 16'h0000, 1, 0, 1,   16'h0005, 1, 0, 0, 0);
      step("tick_0004",      0, 0, 0, 16'h0000, 0, 0, 1,   16'h0004, 1, 0, 0, 0);
      step("rst_mid_run",    1, 0, 0, 16'h0000, 0, 0, 1,   16'h0000, 0, 0, 0, 0);
      step("after_rst",      0, 0, 0, 16'h0000, 0, 0, 1,   16'h0000, 0, 0, 0, 0);
      step("load_0003",      0, 0, 1, 16'h0003, 0, 0, 0,   16'h0003, 0, 0, 0, 0);
      step("start_with_tick",0, 0, 0, 16'h0000, 1, 0, 1,   16'h0003, 1, 0, 0, 0);
      step("first_tick",     0, 0, 0, 16'h0000, 0, 0, 1,   16'h0002, 1, 0, 0, 0);
      step("load_0002",      0, 0, 1, 16'h0002, 0, 0, 0,   16'h0002, 0, 0, 0, 0);
      step("start_0002",     0, 0, 0, 16'h0000, 1, 0, 0,   16'h0002, 1, 0, 0, 0);
      step("tick_0001",      0, 0, 0, 16'h0000, 0, 0, 1,   16'h0001, 1, 0, 0, 0);
      if (auto_rl) begin
         step("reload_1",    0, 0, 0, 16'h0000, 0, 0, 1,   16'h0002, 1, 0, 0, 1);
         step("tick_again",  0, 0, 0, 16'h0000, 0, 0, 1,   16'h0001, 1, 0, 0, 0);
         step("reload_2",    0, 0, 0, 16'h0000, 0, 0, 1,   16'h0002, 1, 0, 0, 1);
         step("clear_shadow",0, 1, 0, 16'h0000, 0, 0, 0,   16'h0000, 0, 0, 0, 0);
      end else begin
         step("expire_0002", 0, 0, 0, 16'h0000, 0, 0, 1,   16'h0000, 0, 0, 1, 1);
         step("load_in_done",0, 0, 1, 16'h0007, 0, 0, 0,   16'h0007, 0, 0, 0, 0);
      end
      @(negedge clk);
      rst = 0; clear = 0; load = 0; preset = '0; start = 0; stop = 0; tick = 0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
